alu_op_sequencer: RTL and testbench

//  Multi-cycle controller that runs one ALU operation per request over the single shared 16-bit bus.

---
 rtl/alu_op_sequencer_pkg.sv | 31 +++
 rtl/alu_op_decode.sv | 26 ++
 rtl/alu_op_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared ALU controller definitions: op codes, shifter select codes and FSM state encodings.
// Imported by alu_op_decode and alu_op_sequencer.
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'b000,
    ALU_AND     = 3'b001,
    ALU_INC_Y2  = 3'b010,
    ALU_INV     = 3'b011,
    ALU_OR      = 3'b100,
    ALU_PASS_Y  = 3'b101,
    ALU_SUB     = 3'b110,
    ALU_ILLEGAL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_LEFT  = 2'b01,
    SHIFT_RIGHT = 2'b10,
    SHIFT_ROT   = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_Y = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op classifier: which datapath resources an ALU op needs, and whether it is illegal.
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [2:0] op,
  output logic       needs_y,
  output logic       needs_bus_a,
  output logic       illegal
);

  always_comb begin
    needs_y     = 1'b0;
    needs_bus_a = 1'b0;
    illegal     = 1'b0;
    case (alu_op_e'(op))
      ALU_ADD, ALU_AND, ALU_OR, ALU_SUB: begin
        needs_y     = 1'b1;
        needs_bus_a = 1'b1;
      end
      ALU_INC_Y2, ALU_PASS_Y: needs_y = 1'b1;
      ALU_INV:                needs_bus_a = 1'b1;
      default:                illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle single-bus ALU op controller: IDLE -> [LOAD_Y] -> EXEC -> WRITE, or ERR for illegal ops.
// Optional FLAG_REG_EN adds zero/negative flag capture from alu_out at the end of EXEC.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int REG_SEL_W = 3
`ifdef FLAG_REG_EN
  , parameter int DATA_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [REG_SEL_W-1:0] req_src_a,
  input  logic [REG_SEL_W-1:0] req_src_b,
  input  logic [REG_SEL_W-1:0] req_dst,
  input  logic [1:0]           req_shift,
  output logic                 reg_out_en,
  output logic [REG_SEL_W-1:0] reg_out_sel,
  output logic                 reg_in_en,
  output logic [REG_SEL_W-1:0] reg_in_sel,
  output logic                 y_in,
  output logic                 z_in,
  output logic                 z_out,
  output logic [2:0]           alu_control,
  output logic [1:0]           shift_ctrl,
  output logic                 done,
  output logic                 err
`ifdef FLAG_REG_EN
  ,
  input  logic [DATA_W-1:0]    alu_out,
  output logic                 flag_z,
  output logic                 flag_n
`endif
);

  state_e                 state_q, state_d, first_state;
  alu_op_e                op_q;
  shift_e                 shift_q;
  logic [REG_SEL_W-1:0]   src_a_q, src_b_q, dst_q;
  logic                   bus_a_q;
  logic                   needs_y, needs_bus_a, illegal;
  logic                   accept;

  alu_op_decode u_decode (
    .op          (req_op),
    .needs_y     (needs_y),
    .needs_bus_a (needs_bus_a),
    .illegal     (illegal)
  );

  // WRITE accepts so a new op's first state follows write-back with no bubble.
  assign req_ready   = (state_q == ST_IDLE) || (state_q == ST_WRITE);
  assign accept      = req_valid & req_ready;
  assign first_state = illegal ? ST_ERR : (needs_y ? ST_LOAD_Y : ST_EXEC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_ADD;
      shift_q <= SHIFT_NONE;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      bus_a_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= alu_op_e'(req_op);
        shift_q <= shift_e'(req_shift);
        src_a_q <= req_src_a;
        src_b_q <= req_src_b;
        dst_q   <= req_dst;
        bus_a_q <= needs_bus_a;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    reg_out_en  = 1'b0;
    reg_out_sel = '0;
    reg_in_en   = 1'b0;
    reg_in_sel  = '0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    z_out       = 1'b0;
    alu_control = 3'b000;
    shift_ctrl  = 2'b00;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = first_state;
      end
      ST_LOAD_Y: begin
        reg_out_en  = 1'b1;
        reg_out_sel = src_b_q;
        y_in        = 1'b1;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        alu_control = op_q;
        shift_ctrl  = shift_q;
        z_in        = 1'b1;
        // inc_Y_2 / pass_Y work on Y alone, so the bus is left undriven.
        reg_out_en  = bus_a_q;
        reg_out_sel = bus_a_q ? src_a_q : '0;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        z_out      = 1'b1;
        reg_in_en  = 1'b1;
        reg_in_sel = dst_q;
        done       = 1'b1;
        state_d    = accept ? first_state : ST_IDLE;
      end
      ST_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FLAG_REG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      flag_z <= (alu_out == '0);
      flag_n <= alu_out[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: expected per-cycle strobe records queued at accept,
// popped by an independent negedge monitor whenever the DUT shows activity.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic       oe;
    logic [2:0] osel;
    logic       ie;
    logic [2:0] isel;
    logic       y;
    logic       zi;
    logic       zo;
    logic [2:0] alu;
    logic [1:0] sh;
    logic       dn;
    logic       er;
    logic       rdy;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [2:0] req_src_a, req_src_b, req_dst;
  logic [1:0] req_shift;
  logic       reg_out_en, reg_in_en, y_in, z_in, z_out, done, err;
  logic [2:0] reg_out_sel, reg_in_sel, alu_control;
  logic [1:0] shift_ctrl;
`ifdef FLAG_REG_EN
  logic [15:0] alu_out;
  logic        flag_z, flag_n;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   last_done = 0;
  int   prev_done = 0;
  rec_t expq[$];
  int   tagq[$];

  alu_op_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src_a   (req_src_a),
    .req_src_b   (req_src_b),
    .req_dst     (req_dst),
    .req_shift   (req_shift),
    .reg_out_en  (reg_out_en),
    .reg_out_sel (reg_out_sel),
    .reg_in_en   (reg_in_en),
    .reg_in_sel  (reg_in_sel),
    .y_in        (y_in),
    .z_in        (z_in),
    .z_out       (z_out),
    .alu_control (alu_control),
    .shift_ctrl  (shift_ctrl),
    .done        (done),
    .err         (err)
`ifdef FLAG_REG_EN
    ,
    .alu_out     (alu_out),
    .flag_z      (flag_z),
    .flag_n      (flag_n)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t get_rec();
    rec_t r;
    r = '{oe: reg_out_en, osel: reg_out_sel, ie: reg_in_en, isel: reg_in_sel, y: y_in,
          zi: z_in, zo: z_out, alu: alu_control, sh: shift_ctrl, dn: done, er: err,
          rdy: req_ready};
    return r;
  endfunction

  function automatic rec_t r_idle();
    rec_t r = '0;
    r.rdy = 1'b1;
    return r;
  endfunction

  function automatic rec_t r_load(input logic [2:0] b);
    rec_t r = '0;
    r.oe = 1'b1; r.osel = b; r.y = 1'b1;
    return r;
  endfunction

  function automatic rec_t r_exec(input logic oe, input logic [2:0] sel,
                                  input logic [2:0] alu, input logic [1:0] sh);
    rec_t r = '0;
    r.oe = oe; r.osel = sel; r.zi = 1'b1; r.alu = alu; r.sh = sh;
    return r;
  endfunction

  function automatic rec_t r_write(input logic [2:0] d);
    rec_t r = '0;
    r.zo = 1'b1; r.ie = 1'b1; r.isel = d; r.dn = 1'b1; r.rdy = 1'b1;
    return r;
  endfunction

  function automatic rec_t r_err();
    rec_t r = '0;
    r.dn = 1'b1; r.er = 1'b1;
    return r;
  endfunction

  task automatic push(input rec_t r, input int tag);
    expq.push_back(r);
    tagq.push_back(tag);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: any active strobe consumes one expected record.
  always @(negedge clk) begin
    rec_t g, e;
    int   t;
    g = get_rec();
    if ((g.oe | g.ie | g.y | g.zi | g.zo | g.dn | g.er) === 1'b1) begin
      if (g.dn === 1'b1) begin
        prev_done = last_done;
        last_done = cyc;
      end
      n_checks++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_activity @cyc %0d: got %h, expected no activity", cyc, g);
      end else begin
        e = expq.pop_front();
        t = tagq.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL record_%0d @cyc %0d: got %h, expected %h", t, cyc, g, e);
        end
      end
      n_checks++;
      if (g.oe && g.zo) begin
        n_fail++;
        $display("FAIL bus_conflict @cyc %0d: reg_out_en=%b z_out=%b, expected one driver",
                 cyc, g.oe, g.zo);
      end
    end else if (reset === 1'b0) begin
      n_checks++;
      if (g !== r_idle()) begin
        n_fail++;
        $display("FAIL idle_outputs @cyc %0d: got %h, expected %h", cyc, g, r_idle());
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic [1:0] sh);
    int waited = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_op = op; req_src_a = a; req_src_b = b; req_dst = d; req_shift = sh;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready=%b, expected 1 within 20 cycles", req_ready);
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (expq.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_int({name, "_drained"}, expq.size(), 0);
    expq.delete();
    tagq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0;
    req_src_a = '0; req_src_b = '0; req_dst = '0; req_shift = '0;
`ifdef FLAG_REG_EN
    alu_out = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (get_rec() !== r_idle()) begin
      n_fail++;
      $display("FAIL reset_state: got %h, expected %h", get_rec(), r_idle());
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // add r1,r2 -> r3
    issue(3'b000, 3'd1, 3'd2, 3'd3, 2'b00);
    push(r_load(3'd2), 11);
    push(r_exec(1'b1, 3'd1, 3'b000, 2'b00), 12);
    push(r_write(3'd3), 13);
    drain("add");
    check_int("add_latency", last_done - acc_cyc, 3);

    // invert r4 -> r5, no Y load
    issue(3'b011, 3'd4, 3'd7, 3'd5, 2'b01);
    push(r_exec(1'b1, 3'd4, 3'b011, 2'b01), 21);
    push(r_write(3'd5), 22);
    drain("inv");
    check_int("inv_latency", last_done - acc_cyc, 2);

    // pass_Y r6 -> r0, bus undriven in EXEC
    issue(3'b101, 3'd7, 3'd6, 3'd0, 2'b10);
    push(r_load(3'd6), 31);
    push(r_exec(1'b0, 3'd0, 3'b101, 2'b10), 32);
    push(r_write(3'd0), 33);
    drain("pass");
    check_int("pass_latency", last_done - acc_cyc, 3);

    // illegal op
    issue(3'b111, 3'd1, 3'd2, 3'd3, 2'b00);
    push(r_err(), 41);
    drain("illegal");
    check_int("err_latency", last_done - acc_cyc, 1);

    // inc_Y_2 r1 -> r2, dst equals an unused src_a
    issue(3'b010, 3'd2, 3'd1, 3'd2, 2'b11);
    push(r_load(3'd1), 45);
    push(r_exec(1'b0, 3'd0, 3'b010, 2'b11), 46);
    push(r_write(3'd2), 47);
    drain("inc");

    // sub then and, second accepted during first's WRITE
    issue(3'b110, 3'd2, 3'd3, 3'd4, 2'b00);
    push(r_load(3'd3), 51);
    push(r_exec(1'b1, 3'd2, 3'b110, 2'b00), 52);
    push(r_write(3'd4), 53);
    issue(3'b001, 3'd5, 3'd6, 3'd7, 2'b11);
    push(r_load(3'd6), 54);
    push(r_exec(1'b1, 3'd5, 3'b001, 2'b11), 55);
    push(r_write(3'd7), 56);
    drain("b2b");
    check_int("b2b_done_spacing", last_done - prev_done, 3);

    // reset during EXEC abandons the op
    issue(3'b000, 3'd1, 3'd2, 3'd3, 2'b00);
    push(r_load(3'd2), 61);
    push(r_exec(1'b1, 3'd1, 3'b000, 2'b00), 62);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (get_rec() !== r_idle()) begin
      n_fail++;
      $display("FAIL reset_mid_op: got %h, expected %h", get_rec(), r_idle());
    end
    repeat (4) @(negedge clk);
    check_int("reset_no_pending", expq.size(), 0);

`ifdef FLAG_REG_EN
    alu_out = 16'h0000;
    issue(3'b110, 3'd1, 3'd1, 3'd2, 2'b00);
    push(r_load(3'd1), 71);
    push(r_exec(1'b1, 3'd1, 3'b110, 2'b00), 72);
    push(r_write(3'd2), 73);
    drain("flag_sub");
    check_int("flag_z_zero", int'(flag_z), 1);
    check_int("flag_n_zero", int'(flag_n), 0);
    alu_out = 16'h8001;
    issue(3'b000, 3'd1, 3'd2, 3'd3, 2'b00);
    push(r_load(3'd2), 74);
    push(r_exec(1'b1, 3'd1, 3'b000, 2'b00), 75);
    push(r_write(3'd3), 76);
    drain("flag_add");
    check_int("flag_z_neg", int'(flag_z), 0);
    check_int("flag_n_neg", int'(flag_n), 1);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
